// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the streaming FIR convolution block:
//   - default parameter constants for fir_stream_conv
//   - FSM state encoding (IDLE, MAC, OUT)
//   - acc_w(): accumulator width that cannot overflow for a given configuration
// -----------------------------------------------------------------------------
package fir_pkg;

    localparam int TAPS_DEF      = 20;
    localparam int DATA_W_DEF    = 16;
    localparam int COEF_W_DEF    = 16;
    localparam int OUT_W_DEF     = 16;
    localparam int FRAC_BITS_DEF = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_e;

    // Full-precision product plus log2(TAPS) guard bits for the running sum.
    function automatic int acc_w(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_mac.sv
// -----------------------------------------------------------------------------
// fir_mac
// Single signed multiply-accumulate stage with a registered accumulator.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset, clears the accumulator
//   clr_i  - load zero into the accumulator (takes priority over en_i)
//   en_i   - add a_i*b_i to the accumulator
//   a_i    - signed sample operand
//   b_i    - signed coefficient operand
//   acc_o  - accumulator value
// -----------------------------------------------------------------------------
module fir_mac
    import fir_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int COEF_W = COEF_W_DEF,
    parameter int ACC_W  = acc_w(DATA_W_DEF, COEF_W_DEF, TAPS_DEF)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [COEF_W-1:0] b_i,
    output logic signed [ACC_W-1:0]  acc_o
);

    logic signed [DATA_W+COEF_W-1:0] prod;
    logic signed [ACC_W-1:0]         acc_q;
    logic signed [ACC_W-1:0]         acc_d;

    assign prod = a_i * b_i;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/fir_stream_conv.sv
// -----------------------------------------------------------------------------
// fir_stream_conv
// Streaming FIR: y[n] = sum_k c[k]*x[n-k], one MAC per cycle, result shifted
// right by FRAC_BITS and narrowed to OUT_W bits.
// Build option: define FIR_SATURATE_EN to clamp the narrowed result; otherwise
// it wraps (low OUT_W bits kept).
// Ports:
//   clk, rst              - clock / synchronous active-high reset
//   coef_wr_en/addr/data  - coefficient write port (honoured only in IDLE)
//   in_valid/in_data/in_ready   - sample input handshake
//   flush                 - pulse: inject TAPS-1 zero samples to drain the tail
//   out_valid/out_data/out_ready - result output handshake
//   busy                  - FSM not in IDLE
//   done                  - one-cycle pulse after the last flushed result
// -----------------------------------------------------------------------------
module fir_stream_conv
    import fir_pkg::*;
#(
    parameter int TAPS      = TAPS_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int COEF_W    = COEF_W_DEF,
    parameter int OUT_W     = OUT_W_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      coef_wr_en,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]  coef_data,
    input  logic                      in_valid,
    input  logic signed [DATA_W-1:0]  in_data,
    output logic                      in_ready,
    input  logic                      flush,
    output logic                      out_valid,
    output logic signed [OUT_W-1:0]   out_data,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      done
);

    localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);
    localparam int ADDR_W = $clog2(TAPS);
    localparam int CNT_W  = $clog2(TAPS + 1);

    fir_state_e                state_q;
    logic [CNT_W-1:0]          tap_q;
    logic                      pend_q;
    logic [CNT_W-1:0]          zleft_q;
    logic                      out_valid_q;
    logic signed [OUT_W-1:0]   out_data_q;
    logic                      done_q;

    logic signed [DATA_W-1:0]  dly_q [TAPS];
    logic signed [DATA_W-1:0]  dly_d [TAPS];
    logic signed [COEF_W-1:0]  coef_q [TAPS];

    logic                      accept;
    logic                      inject;
    logic                      shift_en;
    logic                      flush_last;
    logic                      mac_en;
    logic [ADDR_W-1:0]         tap_idx;
    logic signed [DATA_W-1:0]  shift_in;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [OUT_W-1:0]   narrowed;

    assign in_ready   = (state_q == IDLE) && !pend_q && !rst;
    assign accept     = in_valid && in_ready;
    // A pending flush feeds one zero sample per IDLE visit until the tail is out.
    assign inject     = (state_q == IDLE) && pend_q && (zleft_q != '0);
    assign shift_en   = accept || inject;
    assign shift_in   = accept ? in_data : '0;
    // Handshake of the result produced by the final injected zero.
    assign flush_last = (state_q == OUT) && out_ready && pend_q && (zleft_q == '0);
    // MAC runs TAPS multiply cycles, then one more cycle to register the result.
    assign mac_en     = (state_q == MAC) && (tap_q != CNT_W'(TAPS));
    assign tap_idx    = tap_q[ADDR_W-1:0];

    // Delay line: newest sample at index 0.
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_dly
        if (gi == 0) begin : g_head
            assign dly_d[gi] = shift_in;
        end else begin : g_shift
            assign dly_d[gi] = dly_q[gi-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_last) begin
            for (int i = 0; i < TAPS; i++) begin
                dly_q[i] <= '0;
            end
        end else if (shift_en) begin
            dly_q <= dly_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                coef_q[i] <= '0;
            end
        end else if (coef_wr_en && (state_q == IDLE) &&
                     ({1'b0, coef_addr} < (ADDR_W+1)'(TAPS))) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    fir_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clr_i (shift_en),
        .en_i  (mac_en),
        .a_i   (dly_q[tap_idx]),
        .b_i   (coef_q[tap_idx]),
        .acc_o (acc)
    );

    assign shifted = acc >>> FRAC_BITS;

`ifdef FIR_SATURATE_EN
    // In range exactly when every bit above the OUT_W sign bit matches it.
    logic [ACC_W-OUT_W:0] head;
    assign head = shifted[ACC_W-1:OUT_W-1];

    always_comb begin
        narrowed = shifted[OUT_W-1:0];
        if (head != '0 && head != '1) begin
            narrowed = shifted[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                        : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    assign narrowed = OUT_W'(shifted);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tap_q       <= '0;
            pend_q      <= 1'b0;
            zleft_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // A flush arriving while one is already pending is absorbed.
            if (flush && !pend_q) begin
                pend_q  <= 1'b1;
                zleft_q <= CNT_W'(TAPS - 1);
            end
            case (state_q)
                IDLE: begin
                    if (shift_en) begin
                        state_q <= MAC;
                        tap_q   <= '0;
                        if (inject) begin
                            zleft_q <= zleft_q - 1'b1;
                        end
                    end
                end
                MAC: begin
                    if (tap_q == CNT_W'(TAPS)) begin
                        state_q     <= OUT;
                        out_valid_q <= 1'b1;
                        out_data_q  <= narrowed;
                    end else begin
                        tap_q <= tap_q + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        if (flush_last) begin
                            pend_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_fir_stream_conv.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fir_stream_conv
// Scoreboard bench: the stimulus side computes each expected result from a
// plain convolution model and queues it; a monitor pops and compares on every
// output handshake, and also checks latency, stall stability and done pulses.
// -----------------------------------------------------------------------------
module tb_fir_stream_conv;

    localparam int TAPS      = 4;
    localparam int DATA_W    = 16;
    localparam int COEF_W    = 16;
    localparam int OUT_W     = 16;
    localparam int FRAC_BITS = 14;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     coef_wr_en;
    logic [1:0]               coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_ready;
    logic                     flush;
    logic                     out_valid;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_ready;
    logic                     busy;
    logic                     done;

    fir_stream_conv #(
        .TAPS      (TAPS),
        .DATA_W    (DATA_W),
        .COEF_W    (COEF_W),
        .OUT_W     (OUT_W),
        .FRAC_BITS (FRAC_BITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .coef_wr_en (coef_wr_en),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int data;
        int acc_cyc;
        bit timed;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   hist[$];
    int   cm[TAPS];
    int   total  = 0;
    int   passed = 0;
    int   n_out  = 0;
    bit   rand_ready  = 1'b0;
    bit   force_ready = 1'b1;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    function automatic int s16(input int v);
        logic signed [15:0] t;
        t = 16'(v);
        return int'(t);
    endfunction

    // y = sum c[k]*x[n-k], >>> FRAC_BITS, then clamp or wrap to 16 bits.
    function automatic int model_out();
        longint acc = 0;
        longint sh;
        for (int k = 0; k < TAPS; k++) begin
            if (k < hist.size()) acc += longint'(cm[k]) * longint'(hist[k]);
        end
        sh = acc >>> FRAC_BITS;
`ifdef FIR_SATURATE_EN
        if (sh > 32767) sh = 32767;
        if (sh < -32768) sh = -32768;
`else
        sh = sh & 64'hFFFF;
        if (sh >= 32768) sh -= 65536;
`endif
        return int'(sh);
    endfunction

    function automatic void model_push(input int x);
        hist.push_front(x);
        while (hist.size() > TAPS) void'(hist.pop_back());
    endfunction

    function automatic void model_flush();
        for (int i = 0; i < TAPS - 1; i++) begin
            exp_t e;
            model_push(0);
            e.data = model_out();
            e.acc_cyc = 0;
            e.timed = 1'b0;
            e.last = (i == TAPS - 2);
            exp_q.push_back(e);
        end
        hist.delete();
    endfunction

    // All driver tasks start and end on a falling edge.
    task automatic write_coef(input int addr, input int val, input bit model_upd);
        coef_wr_en = 1'b1;
        coef_addr  = 2'(addr);
        coef_data  = 16'(val);
        @(negedge clk);
        coef_wr_en = 1'b0;
        if (model_upd) cm[addr] = s16(val);
    endtask

    task automatic send_sample(input int val, input bit with_flush);
        int   waited = 0;
        exp_t e;
        in_valid = 1'b1;
        in_data  = 16'(val);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("accept_timeout", int'(in_ready), 1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        flush = with_flush;
        model_push(s16(val));
        e.data = model_out();
        e.acc_cyc = cyc + 1;
        e.timed = 1'b1;
        e.last = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        if (with_flush) model_flush();
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_flush();
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain", int'(exp_q.size() != 0 || busy), 0);
        @(negedge clk);
    endtask

    // out_ready changes just after the rising edge so the monitor sees it settled.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : force_ready;
        end
    end

    // Monitor / scoreboard.
    initial begin
        bit   prev_valid = 1'b0;
        bit   done_exp   = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (done || done_exp) check("done_pulse", int'(done), int'(done_exp));
                done_exp = 1'b0;
                if (out_valid && !prev_valid) begin
                    if (exp_q.size() == 0) check("unexpected_out_valid", int'(out_valid), 0);
                    else if (exp_q[0].timed) check("latency", cyc - exp_q[0].acc_cyc, TAPS + 1);
                end
                if (out_valid && !out_ready && exp_q.size() != 0) begin
                    check("stall_hold", int'(out_data), exp_q[0].data);
                    check("stall_in_ready", int'(in_ready), 0);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_output", int'(out_valid), 0);
                    end else begin
                        e = exp_q.pop_front();
                        n_out++;
                        $display("txn %0d: out_data=%0d expected=%0d cycle=%0d", n_out, out_data, e.data, cyc);
                        check("out_data", int'(out_data), e.data);
                        if (e.last) done_exp = 1'b1;
                    end
                end
                prev_valid = out_valid;
            end else begin
                prev_valid = 1'b0;
                done_exp   = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; coef_wr_en = 1'b0; coef_addr = '0; coef_data = '0;
        in_valid = 1'b0; in_data = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_out_data", int'(out_data), 0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", int'(in_ready), 1);

        // Impulse response.
        write_coef(0, 16384, 1); write_coef(1, 8192, 1);
        write_coef(2, -4096, 1); write_coef(3, 0, 1);
        send_sample(16384, 0); send_sample(0, 0); send_sample(0, 0); send_sample(0, 0);
        wait_drain();

        // Full-scale accumulation: saturation or wrap on the fourth result.
        for (int i = 0; i < TAPS; i++) write_coef(i, 32767, 1);
        for (int i = 0; i < TAPS; i++) send_sample(32767, 0);
        wait_drain();

        // Backpressure: result held for 6 cycles, next sample must wait.
        send_sample(12000, 0);
        force_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        check("bp_out_valid", int'(out_valid), 1);
        in_valid = 1'b1; in_data = 16'(-7000);
        repeat (6) begin
            @(negedge clk);
            check("bp_in_ready", int'(in_ready), 0);
        end
        force_ready = 1'b1;
        send_sample(-7000, 0);
        wait_drain();

        // Flush: three samples, tail of three results, then a clean impulse.
        write_coef(0, 16384, 1); write_coef(1, 8192, 1);
        write_coef(2, -4096, 1); write_coef(3, 4096, 1);
        send_sample(1234, 0); send_sample(-20000, 0); send_sample(30000, 0);
        flush_pulse();
        wait_drain();
        send_sample(16384, 0); send_sample(0, 0); send_sample(0, 0); send_sample(0, 0);
        wait_drain();

        // Coefficient write while busy is ignored.
        send_sample(1000, 0);
        write_coef(0, 12345, 0);
        wait_drain();
        send_sample(16384, 0);
        wait_drain();

        // Reset during the second MAC cycle aborts the computation.
        send_sample(5000, 0);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        hist.delete();
        for (int i = 0; i < TAPS; i++) cm[i] = 0;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_done", int'(done), 0);
        repeat (10) @(negedge clk);
        check("abort_in_ready", int'(in_ready), 1);
        send_sample(20000, 0);
        wait_drain();

        // Randomised traffic with random stalls, flushes and coefficient updates.
        for (int i = 0; i < TAPS; i++) write_coef(i, int'($urandom), 1);
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int r;
            r = int'($urandom_range(0, 11));
            if (r == 0) begin
                wait_drain();
                write_coef(int'($urandom_range(0, TAPS - 1)), int'($urandom), 1);
            end else if (r == 1) begin
                send_sample(int'($urandom), 1);
            end else begin
                send_sample(int'($urandom), 0);
            end
        end
        wait_drain();
        rand_ready = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fir_stream_conv.md
FIR_STREAM_CONV -- requirements
Module: fir_stream_conv

Interface
REQ-001 SHALL provide parameters, one per line:
- TAPS, 20, filter length.
- DATA_W, 16, signed sample width.
- COEF_W, 16, signed coefficient width.
- OUT_W, 16, signed output width.
- FRAC_BITS, 14, arithmetic right shift applied to the accumulator.
REQ-002 SHALL use one clock; reset is synchronous and active-high. Ports, one per line:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- coef_wr_en  in  1  coefficient write strobe.
- coef_addr  in  $clog2(TAPS)  tap index.
- coef_data  in  COEF_W  signed coefficient.
- in_valid  in  1  sample offered.
- in_data  in  DATA_W  signed sample.
- in_ready  out  1  sample accepted when in_valid && in_ready.
- flush  in  1  one-cycle request to drain the convolution tail.
- out_valid  out  1  result offered.
- out_data  out  OUT_W  signed result.
- out_ready  in  1  result consumed when out_valid && out_ready.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a flush completes.

Function
REQ-003 SHALL compute y[n] = sum over k=0..TAPS-1 of c[k]*x[n-k] (streaming full convolution); the delay line holds TAPS samples, newest at index 0.
REQ-004 SHALL use FSM states IDLE, MAC, OUT: IDLE->MAC on accepting a sample or flush zero; MAC->OUT after TAPS cycles; OUT->IDLE on out_ready.
REQ-005 SHALL perform one signed multiply-accumulate per cycle in MAC, so out_valid rises exactly TAPS+1 cycles after the accepting edge.
REQ-006 SHALL size the accumulator ACC_W = DATA_W+COEF_W+$clog2(TAPS) bits; the accumulator cannot overflow.
REQ-007 SHALL form out_data = (acc >>> FRAC_BITS) narrowed to OUT_W bits according to REQ-015.
REQ-008 SHALL assert in_ready only in IDLE with no flush pending; out_data SHALL stay stable while out_valid && !out_ready.
REQ-009 SHALL accept coefficient writes only in IDLE; writes while busy SHALL be ignored.
REQ-010 SHALL latch a flush pulse into a pending flag; while the flag is set, in_ready=0 and TAPS-1 zero samples are injected, one per IDLE visit.
REQ-011 SHALL pulse done for one cycle at the OUT->IDLE transition of the last flushed output; afterwards the delay line is all-zero and the flag is clear.
REQ-012 SHALL give in_valid priority over flush when both arrive in the same IDLE cycle; the flush is still latched.

Reset
REQ-013 SHALL, on rst, clear the delay line, coefficients, accumulator and flush flag, enter IDLE, and drive out_valid=0, out_data=0, busy=0, done=0, in_ready=0 (in_ready=1 from the first cycle after).
REQ-014 SHALL let rst mid-MAC or mid-flush abort the operation; no out_valid or done follows.

Configuration
REQ-015 SHALL support macro FIR_SATURATE_EN:
- Defined: the shifted accumulator clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Undefined: it is truncated to its low OUT_W bits (two's-complement wrap).

Structure
REQ-016 SHALL place the state enum, the ACC_W function and the default parameter constants in package fir_pkg.
REQ-017 SHALL implement the multiply-accumulate datapath in sub-module fir_mac (clear, enable, operands, accumulator out).

Verification
Benches use TAPS=4, DATA_W=COEF_W=OUT_W=16, FRAC_BITS=14.
REQ-018 Impulse: coefs {16384, 8192, -4096, 0}, then samples 16384, 0, 0, 0 -> outputs 16384, 8192, -4096, 0, each exactly 5 cycles after acceptance.
REQ-019 Overflow: all coefs 32767, four samples of 32767 -> fourth output is 32767 with FIR_SATURATE_EN defined, -16 (0xFFF0) without it.
REQ-020 Backpressure: out_ready held low for 6 cycles -> out_data stable, in_ready=0, no sample lost.
REQ-021 Flush: 3 samples then a flush pulse -> exactly 3 further outputs (the tail), done high one cycle, next impulse yields the pure coefficient sequence.
REQ-022 Busy write/reset: coef write during MAC is ignored; rst asserted in MAC cycle 2 -> no out_valid, busy=0 the next cycle.
